shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: data and shift-register width in bits.
REQ-002 Parameter CNT_W, default 3: shift-count width in bits (0..2^CNT_W-1 shifts).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_data  input  WIDTH  value loaded before shifting.
REQ-008 cmd_dir  input  1  0 = shift right (toward LSB), 1 = shift left (toward MSB).
REQ-009 cmd_count  input  CNT_W  number of single-bit shifts.
REQ-010 busy  output  1  a command is in progress.
REQ-011 done  output  1  one-cycle pulse; result is final.
REQ-012 result  output  WIDTH  current shift-register contents.

Function
REQ-013 States: IDLE, LOAD, SHIFT, DONE.
REQ-014 A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE.
REQ-015 On acceptance, the FSM latches cmd_data, cmd_dir and cmd_count, then moves IDLE->LOAD.
REQ-016 In LOAD, core controls {load,mode}=11, so the register takes the latched data on the next edge.
REQ-017 LOAD->SHIFT if the latched count != 0; otherwise LOAD->DONE.
REQ-018 Each SHIFT cycle applies exactly one shift per edge and decrements the remaining count:
- right: {load,mode}=01
- left: {load,mode}=10
- vacated bit filled with 0
REQ-019 SHIFT->DONE on the edge where the remaining count reaches 0.
REQ-020 In DONE, done=1 for exactly one cycle, the register holds ({load,mode}=00), and the FSM returns to IDLE.
REQ-021 Latency: done is asserted in the cycle after the (count+1)th rising edge following the acceptance edge.
REQ-022 Minimum command-to-command spacing: count+3 cycles.
REQ-023 busy=1 in LOAD, SHIFT and DONE; busy=0 in IDLE.
REQ-024 cmd_valid while busy is ignored; the in-flight command is not altered, and no command is queued.
REQ-025 result always reflects the register and holds its value in IDLE until the next LOAD.
REQ-026 cmd_count at maximum (7 at default): all bits shift out; the result is 0.

Reset
REQ-027 reset=1, asynchronously and at any state including mid-SHIFT:
- FSM->IDLE
- register=0, result=0
- done=0, busy=0, cmd_ready=1 after release
- latched count=0
REQ-028 A command presented in the same cycle reset deasserts is accepted only on a subsequent edge where reset=0.

Configuration
REQ-029 Macro SHIFT_SEQUENCER_ROTATE_EN. When defined:
- an input cmd_rot (1 bit, latched at acceptance) is added;
- cmd_rot=1 makes each SHIFT step a rotation (bit shifted out re-enters at the opposite end);
- cmd_rot=0 keeps zero-fill shifts.
REQ-030 Without SHIFT_SEQUENCER_ROTATE_EN: cmd_rot is absent and all shifts are zero-fill.

Structure
REQ-031 Shared package shift_seq_pkg holds:
- the state enum (IDLE, LOAD, SHIFT, DONE);
- {load,mode} encoding constants: HOLD=00, SHR=01, SHL=10, LD=11.
REQ-032 One sub-module, shift_reg_core: WIDTH-bit register with the HOLD/SHR/SHL/LD encoding, asynchronous active-high reset to 0, and an optional rotate input under SHIFT_SEQUENCER_ROTATE_EN. The FSM, count and handshake live in shift_sequencer.

Verification
REQ-033 data=1011, dir=0, count=2 -> result 0010; done 3 cycles after acceptance edge; busy high throughout.
REQ-034 data=1011, dir=1, count=0 -> no SHIFT state; done 1 cycle after acceptance edge; result 1011.
REQ-035 data=1111, dir=1, count=7 -> result 0000; done one cycle only; cmd_ready=1 the following cycle.
REQ-036 Command data=0110, dir=0, count=5; second command with cmd_valid held during busy -> second command accepted only after DONE->IDLE; first result 0000 unaffected.
REQ-037 Reset asserted mid-SHIFT (data=1001, dir=1, count=4, after 2 shifts) -> result 0000, busy 0, no done pulse; fresh command afterwards completes normally.
REQ-038 With SHIFT_SEQUENCER_ROTATE_EN: data=1001, dir=0, rot=1, count=1 -> result 1100. Same stimulus with rot=0 -> 0100.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and the
// {load,mode} control word understood by shift_reg_core.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN (adds rotate shifts).
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef logic [1:0] ctl_t;

  // {load,mode} encodings
  localparam ctl_t HOLD = 2'b00;
  localparam ctl_t SHR  = 2'b01;
  localparam ctl_t SHL  = 2'b10;
  localparam ctl_t LD   = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command / status bundle of the shift sequencer.
// master = command source, slave = the sequencer.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN adds cmd_rot.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic             cmd_rot;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    output cmd_rot,
`endif
    input  cmd_ready, busy, done, result
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    input  cmd_rot,
`endif
    output cmd_ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer_core.sv
// shift_reg_core: WIDTH-bit register driven by the {load,mode} control word.
// Vacated bits are zero-filled unless rotation is compiled in
// (SHIFT_SEQUENCER_ROTATE_EN) and requested through rot.
module shift_reg_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  ctl_t             ctl,
  input  logic [WIDTH-1:0] din,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q
);

  logic fill_r;
  logic fill_l;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  assign fill_r = rot & q[0];
  assign fill_l = rot & q[WIDTH-1];
`else
  assign fill_r = 1'b0;
  assign fill_l = 1'b0;
`endif

  // register update: hold, shift right, shift left or parallel load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (ctl)
        LD:      q <= din;
        SHR:     q <= {fill_r, q[WIDTH-1:1]};
        SHL:     q <= {q[WIDTH-2:0], fill_l};
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one command at a time, loads the data into the
// shift core, applies cmd_count single-bit shifts, then pulses done.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN (per-command rotation).
//
// state | meaning
// IDLE  | ready for a command, register holds last result
// LOAD  | core loads latched data on the next edge
// SHIFT | one shift per edge, remaining count decrements
// DONE  | one-cycle done pulse, register holds
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  shift_sequencer_if.slave bus
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] count_q;
  ctl_t             ctl;
  logic             ready;
  logic             busy;
  logic             done;
  logic             accept;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic             rot_q;
`endif

  assign accept = bus.cmd_valid & ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic; SHIFT exits on the edge that takes the count to zero
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = (count_q != '0) ? SHIFT : DONE;
      SHIFT:   if (count_q == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // per-state outputs and core control word
  always_comb begin
    ctl   = HOLD;
    ready = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      LOAD:    ctl  = LD;
      SHIFT:   ctl  = dir_q ? SHL : SHR;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // command latch at acceptance, remaining-shift down-counter during SHIFT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else if (accept) begin
      data_q  <= bus.cmd_data;
      dir_q   <= bus.cmd_dir;
      count_q <= bus.cmd_count;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q   <= bus.cmd_rot;
`endif
    end else if (state == SHIFT) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl),
    .din   (data_q),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .rot   (rot_q),
`endif
    .q     (bus.result)
  );

  assign bus.cmd_ready = ready;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// timeline model of each command. Covers SHIFT_SEQUENCER_ROTATE_EN if defined.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // free-running edge index used to measure latencies
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] shift_n(input logic [3:0] d, input logic dir,
                                         input logic rot, input int k);
    int v;
    v = int'(d);
    for (int i = 0; i < k; i++) begin
      if (dir) v = ((v * 2) % 16) + (rot ? (v / 8) : 0);
      else     v = (v / 2) + (rot ? ((v % 2) * 8) : 0);
    end
    return 4'(v);
  endfunction

  // model: one in-flight command described by acceptance edge and fields
  bit         m_active = 0;
  int         m_n = 0;
  int         m_a = 0;
  int         m_c = 0;
  logic [3:0] m_d = '0;
  logic [3:0] m_last = '0;
  logic       m_dir = 0;
  logic       m_rot = 0;

  // model update at each edge: accept when idle, retire count+2 edges later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      m_last   = '0;
    end else begin
      m_n++;
      if (!m_active) begin
        if (bus.cmd_valid === 1'b1) begin
          m_active = 1;
          m_a      = m_n;
          m_d      = bus.cmd_data;
          m_dir    = bus.cmd_dir;
          m_c      = int'(bus.cmd_count);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
          m_rot    = bus.cmd_rot;
`else
          m_rot    = 1'b0;
`endif
        end
      end else if (m_n - m_a == m_c + 2) begin
        m_active = 0;
        m_last   = shift_n(m_d, m_dir, m_rot, m_c);
      end
    end
  end

  int         k;
  logic [3:0] e_res;
  logic       e_busy, e_done, e_ready;

  // compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (!m_active) begin
      e_res = m_last; e_busy = 0; e_done = 0; e_ready = 1;
    end else begin
      k       = m_n - m_a;
      e_busy  = 1;
      e_ready = 0;
      e_done  = (k == m_c + 1);
      e_res   = (k == 0) ? m_last : shift_n(m_d, m_dir, m_rot, (k - 1 < m_c) ? k - 1 : m_c);
    end
    chk("model_result", 32'(bus.result), 32'(e_res));
    chk("model_busy", 32'(bus.busy), 32'(e_busy));
    chk("model_done", 32'(bus.done), 32'(e_done));
    chk("model_ready", 32'(bus.cmd_ready), 32'(e_ready));
  end

  task automatic drive_cmd(input logic [3:0] d, input logic dir, input logic [2:0] c, input logic rot);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_dir   = dir;
    bus.cmd_count = c;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    bus.cmd_rot   = rot;
`endif
  endtask

  task automatic start_cmd(input logic [3:0] d, input logic dir, input logic [2:0] c,
                           input logic rot, output int acc);
    int guard = 0;
    @(negedge clk); #2;
    drive_cmd(d, dir, c, rot);
    while (!bus.cmd_ready && guard < 40) begin
      @(negedge clk); #2;
      guard++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    acc = edge_cnt;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int acc, output logic [3:0] res, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus.done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.done) chk("done_timeout", 32'(0), 32'(1));
    res = bus.result;
    lat = edge_cnt - acc;
  endtask

  int         acc, acc2, lat;
  logic [3:0] res;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    bus.cmd_rot   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(bus.result), 32'(0));
    chk("reset_ready", 32'(bus.cmd_ready), 32'(1));
    #2 reset = 1'b0;

    // right shift by 2
    start_cmd(4'b1011, 1'b0, 3'd2, 1'b0, acc);
    chk("r2_busy", 32'(bus.busy), 32'(1));
    wait_done(acc, res, lat);
    chk("r2_result", 32'(res), 32'(4'b0010));
    chk("r2_latency", 32'(lat), 32'(3));

    // zero count: load only
    start_cmd(4'b1011, 1'b1, 3'd0, 1'b0, acc);
    wait_done(acc, res, lat);
    chk("c0_result", 32'(res), 32'(4'b1011));
    chk("c0_latency", 32'(lat), 32'(1));

    // maximum count shifts everything out
    start_cmd(4'b1111, 1'b1, 3'd7, 1'b0, acc);
    wait_done(acc, res, lat);
    chk("c7_result", 32'(res), 32'(4'b0000));
    chk("c7_latency", 32'(lat), 32'(8));
    @(negedge clk);
    chk("c7_done_single", 32'(bus.done), 32'(0));
    chk("c7_ready_after", 32'(bus.cmd_ready), 32'(1));

    // second command held valid while first is busy
    start_cmd(4'b0110, 1'b0, 3'd5, 1'b0, acc);
    drive_cmd(4'b1010, 1'b1, 3'd1, 1'b0);
    wait_done(acc, res, lat);
    chk("hold_first_result", 32'(res), 32'(4'b0000));
    start_cmd(4'b1010, 1'b1, 3'd1, 1'b0, acc2);
    chk("hold_second_accept", 32'(acc2 - acc), 32'(8));
    wait_done(acc2, res, lat);
    chk("hold_second_result", 32'(res), 32'(4'b0100));

    // reset in the middle of SHIFT
    start_cmd(4'b1001, 1'b1, 3'd4, 1'b0, acc);
    while (edge_cnt < acc + 3) @(negedge clk);
    chk("mid_two_shifts", 32'(bus.result), 32'(4'b0100));
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_result", 32'(bus.result), 32'(0));
    chk("mid_reset_busy", 32'(bus.busy), 32'(0));
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    start_cmd(4'b0011, 1'b1, 3'd1, 1'b0, acc);
    wait_done(acc, res, lat);
    chk("post_reset_result", 32'(res), 32'(4'b0110));
    chk("post_reset_latency", 32'(lat), 32'(2));

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    start_cmd(4'b1001, 1'b0, 3'd1, 1'b1, acc);
    wait_done(acc, res, lat);
    chk("rot_result", 32'(res), 32'(4'b1100));
    start_cmd(4'b1001, 1'b0, 3'd1, 1'b0, acc);
    wait_done(acc, res, lat);
    chk("norot_result", 32'(res), 32'(4'b0100));
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #2;
      reset = ($urandom_range(0, 99) == 0);
      drive_cmd(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); #2;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
